wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage feeding the register file write port (RegWrite/rd/WriteData).
//  Merges single-cycle ALU results with variable-latency LSU results into one
//  write per cycle. ALU wins arbitration; LSU results are queued in a DEPTH-entry
//  FIFO and drained on free cycles, with a starvation limiter that stalls the ALU.
// PARAMETERS
//  DEPTH         4   LSU result FIFO entries; power of two, >= 2
//  XLEN          32  data width
//  STARVE_LIMIT  8   max consecutive cycles a non-empty FIFO head may wait; >= 1
// PORTS
//  clk              in   1              clock, all state on rising edge
//  rst              in   1              synchronous reset, active-high
//  alu_valid        in   1              ALU result present
//  alu_ready        out  1              ALU result accepted this cycle if alu_valid
//  alu_rd           in   5              ALU destination register
//  alu_data         in   XLEN           ALU result
//  lsu_valid        in   1              LSU result present
//  lsu_ready        out  1              LSU result accepted this cycle if lsu_valid
//  lsu_rd           in   5              LSU destination register
//  lsu_data         in   XLEN           LSU result
//  RegWrite         out  1              register file write enable
//  rd               out  5              register file write address
//  WriteData        out  XLEN           register file write data
//  lsu_pending_mask out  32             bit r set while any FIFO entry targets xr
//  fifo_count       out  $clog2(DEPTH)+1 occupied FIFO entries
// BEHAVIOUR
//  Reset: one clock; rst is synchronous and active-high. While rst=1: FIFO empty,
//   fifo_count=0, starve counter=0, RegWrite=0, rd=0, WriteData=0, mask=0,
//   alu_ready=0, lsu_ready=0; all inputs ignored. Reset mid-stream drops all
//   queued entries and any in-flight write.
//  Handshake: transfer when valid && ready in the same cycle; source holds
//   rd/data stable while valid && !ready.
//  lsu_ready = !rst && fifo_count != DEPTH (no accept when full, even if popping).
//  alu_ready = !rst && starve_cnt < STARVE_LIMIT.
//  x0: accepted transfer with rd==0 is consumed and discarded; ALU rd==0 does not
//   win arbitration; LSU rd==0 is not enqueued; RegWrite never asserts with rd=0.
//  Arbitration per cycle (winner registered to outputs next edge):
//   1) alu_valid && alu_ready && alu_rd!=0 -> write ALU result;
//   2) else FIFO non-empty -> pop head, write it;
//   3) else no write.
//  Latency: ALU accept -> RegWrite=1 next cycle (1). LSU enqueue at edge N ->
//   earliest pop in cycle N+1 -> RegWrite at N+2; no FIFO bypass.
//  Outputs registered; when no write, RegWrite=0, rd=0, WriteData=0.
//  FIFO: in-order; push and pop in the same cycle allowed when not full;
//   pointers wrap modulo DEPTH; fifo_count tracks pushes-pops exactly.
//  Starvation: starve_cnt increments each cycle FIFO non-empty and no pop;
//   clears on pop or when empty; saturates at STARVE_LIMIT. At limit alu_ready=0,
//   so head pops that cycle and counter clears.
//  lsu_pending_mask: combinational OR of one-hot(rd) over valid FIFO entries;
//   updates the cycle after push/pop.
//  WAW ordering between ALU and queued LSU writes to the same rd is NOT enforced
//   here; upstream hazard logic uses lsu_pending_mask to hold such ALU ops.
// TESTING
//  T1 reset: rst=1 2 cycles with valids high -> RegWrite=0, rd=0, readies=0,
//   fifo_count=0; first cycle after: alu_ready=1, lsu_ready=1.
//  T2 ALU only: alu rd=5 data=0xDEADBEEF accepted at cycle N -> cycle N+1
//   RegWrite=1 rd=5 WriteData=0xDEADBEEF; alu rd=0 -> RegWrite=0.
//  T3 LSU fill/drain: alu busy (rd=1) every cycle, LSU pushes rd=10..13 ->
//   fifo_count=4, lsu_ready=0, mask bits 10-13 set; alu_valid=0 -> writes
//   rd=10,11,12,13 on consecutive cycles in order, mask returns to 0.
//  T4 starvation: one queued LSU entry rd=7, continuous ALU writes -> after 8
//   waiting cycles alu_ready=0 one cycle, rd=7 written, alu_ready=1 again.
//  T5 simultaneous: FIFO count 2, push+pop same cycle -> count stays 2; full
//   FIFO with pop -> lsu_ready=0 that cycle, no push; pointer wrap after 9 pushes.
//  T6 reset mid-op: FIFO 3 entries, assert rst -> no further RegWrite, mask=0,
//   count=0; earlier queued data never written.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file write port. ALU results win the write
// slot; LSU results wait in an in-order FIFO, and a starvation limiter stalls the ALU.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [4:0]             lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  output logic                   RegWrite,
  output logic [4:0]             rd,
  output logic [XLEN-1:0]        WriteData,
  output logic [31:0]            lsu_pending_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]      r_q_rd   [DEPTH];
  logic [XLEN-1:0] r_q_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic            w_alu_win;
  logic            w_pop;
  logic            w_push;
  logic            w_empty;
  logic [31:0]     w_mask;

  assign w_empty   = (r_count == '0);
  assign alu_ready = !rst && (r_starve < STARVE_MAX);
  assign lsu_ready = !rst && (r_count != FULL_CNT);
  assign w_alu_win = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign w_pop     = !rst && !w_alu_win && !w_empty;
  // x0 results are accepted and dropped, never occupying a slot
  assign w_push    = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= lsu_rd;
      r_q_data[r_wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Counts cycles the head has waited; reaching the limit drops alu_ready
  always_ff @(posedge clk) begin
    if (rst || w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (w_alu_win) begin
      r_wb_we   <= 1'b1;
      r_wb_rd   <= alu_rd;
      r_wb_data <= alu_data;
    end else if (w_pop) begin
      r_wb_we   <= 1'b1;
      r_wb_rd   <= r_q_rd[r_rd_ptr];
      r_wb_data <= r_q_data[r_rd_ptr];
    end else begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_mask[r_q_rd[i]] = 1'b1;
    end
  end

  // Gating with rst also suppresses a write registered just before reset
  assign RegWrite         = r_wb_we && !rst;
  assign rd               = rst ? 5'd0 : r_wb_rd;
  assign WriteData        = rst ? '0 : r_wb_data;
  assign lsu_pending_mask = rst ? 32'd0 : w_mask;
  assign fifo_count       = rst ? '0 : r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int SLIM  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd, rd;
  logic [XLEN-1:0] alu_data, lsu_data, WriteData;
  logic            RegWrite;
  logic [31:0]     lsu_pending_mask;
  logic [2:0]      fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
    .lsu_pending_mask(lsu_pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            m_q[$];
  int              m_starve = 0;
  logic            m_we = 1'b0;
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_data = '0;

  // Reference model: the queue holds pending LSU writes, outputs follow arbitration rules
  always @(posedge clk) begin
    bit a_rdy, l_rdy, a_win, pop, push;
    if (rst) begin
      m_q.delete();
      m_starve = 0;
      m_we = 0; m_rd = 0; m_data = 0;
    end else begin
      a_rdy = (m_starve < SLIM);
      l_rdy = (m_q.size() != DEPTH);
      a_win = alu_valid && a_rdy && (alu_rd != 0);
      pop   = !a_win && (m_q.size() > 0);
      push  = lsu_valid && l_rdy && (lsu_rd != 0);
      if (a_win) begin
        m_we = 1; m_rd = alu_rd; m_data = alu_data;
      end else if (pop) begin
        m_we = 1; m_rd = m_q[0].rd; m_data = m_q[0].data;
      end else begin
        m_we = 0; m_rd = 0; m_data = 0;
      end
      if (m_q.size() == 0 || pop) m_starve = 0;
      else if (m_starve < SLIM) m_starve++;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back('{rd: lsu_rd, data: lsu_data});
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (m_q[i]) m[m_q[i].rd] = 1'b1;
    return m;
  endfunction

  always @(negedge clk) begin
    chk("RegWrite",  RegWrite,  rst ? 1'b0 : m_we);
    chk("rd",        rd,        rst ? 5'd0 : m_rd);
    chk("WriteData", WriteData, rst ? 32'd0 : m_data);
    chk("alu_ready", alu_ready, !rst && (m_starve < SLIM));
    chk("lsu_ready", lsu_ready, !rst && (m_q.size() != DEPTH));
    chk("fifo_count", fifo_count, rst ? 0 : m_q.size());
    chk("mask",      lsu_pending_mask, rst ? 32'd0 : model_mask());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v; alu_rd = r; alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] r, input logic [31:0] d);
    lsu_valid = v; lsu_rd = r; lsu_data = d;
  endtask

  initial begin
    bit a_hold, l_hold;
    rst = 1;
    set_alu(1, 5'd3, 32'h33);
    set_lsu(1, 5'd4, 32'h44);
    tick();
    // T1 reset with valids high
    repeat (2) begin
      @(negedge clk);
      chk("T1 RegWrite", RegWrite, 0);
      chk("T1 rd", rd, 0);
      chk("T1 alu_ready", alu_ready, 0);
      chk("T1 lsu_ready", lsu_ready, 0);
      chk("T1 count", fifo_count, 0);
      tick();
    end
    rst = 0;
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    @(negedge clk);
    chk("T1 alu_ready after", alu_ready, 1);
    chk("T1 lsu_ready after", lsu_ready, 1);
    tick();

    // T2 ALU only
    set_alu(1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("T2 alu_ready", alu_ready, 1);
    tick();
    set_alu(1, 5'd0, 32'h123);
    @(negedge clk);
    chk("T2 RegWrite", RegWrite, 1);
    chk("T2 rd", rd, 5);
    chk("T2 data", WriteData, 32'hDEADBEEF);
    tick();
    set_alu(0, 0, 0);
    @(negedge clk);
    chk("T2 x0 RegWrite", RegWrite, 0);
    chk("T2 x0 rd", rd, 0);
    tick();

    // T3 fill and drain
    set_alu(1, 5'd1, 32'h11);
    for (int i = 0; i < 4; i++) begin
      set_lsu(1, 5'(10 + i), 32'hA0 + i);
      @(negedge clk);
      chk("T3 lsu_ready fill", lsu_ready, 1);
      tick();
    end
    set_lsu(0, 0, 0);
    @(negedge clk);
    chk("T3 count full", fifo_count, 4);
    chk("T3 model depth", m_q.size(), 4);
    chk("T3 lsu_ready full", lsu_ready, 0);
    chk("T3 mask", lsu_pending_mask, 32'h0000_3C00);
    chk("T3 alu write", rd, 1);
    tick();
    set_alu(0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("T3 drain we", RegWrite, 1);
      chk("T3 drain rd", rd, 10 + i);
      chk("T3 drain data", WriteData, 32'hA0 + i);
      tick();
    end
    @(negedge clk);
    chk("T3 mask empty", lsu_pending_mask, 0);
    chk("T3 no write", RegWrite, 0);
    tick();

    // T4 starvation
    set_alu(1, 5'd2, 32'h22);
    set_lsu(1, 5'd7, 32'h77);
    tick();
    set_lsu(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("T4 alu_ready wait", alu_ready, 1);
      tick();
    end
    @(negedge clk);
    chk("T4 alu_ready stall", alu_ready, 0);
    chk("T4 model starve", m_starve, 8);
    tick();
    @(negedge clk);
    chk("T4 alu_ready back", alu_ready, 1);
    chk("T4 we", RegWrite, 1);
    chk("T4 rd", rd, 7);
    chk("T4 data", WriteData, 32'h77);
    tick();
    set_alu(0, 0, 0);
    tick();

    // T5 simultaneous push/pop and full-with-pop
    set_alu(1, 5'd3, 32'h33);
    set_lsu(1, 5'd20, 32'hB0);
    tick();
    set_lsu(1, 5'd21, 32'hB1);
    tick();
    set_alu(0, 0, 0);
    set_lsu(1, 5'd22, 32'hB2);
    @(negedge clk);
    chk("T5 count before", fifo_count, 2);
    tick();
    set_alu(1, 5'd3, 32'h33);
    set_lsu(1, 5'd23, 32'hB3);
    @(negedge clk);
    chk("T5 count push+pop", fifo_count, 2);
    tick();
    set_lsu(1, 5'd24, 32'hB4);
    tick();
    set_alu(0, 0, 0);
    set_lsu(1, 5'd25, 32'hB5);
    @(negedge clk);
    chk("T5 count full", fifo_count, 4);
    chk("T5 lsu_ready full+pop", lsu_ready, 0);
    tick();
    set_lsu(0, 0, 0);
    @(negedge clk);
    chk("T5 count after pop", fifo_count, 3);
    chk("T5 pop rd", rd, 21);
    tick();
    repeat (4) tick();

    // T6 reset mid-operation
    set_alu(1, 5'd4, 32'h44);
    for (int i = 0; i < 3; i++) begin
      set_lsu(1, 5'(26 + i), 32'hC0 + i);
      tick();
    end
    set_lsu(0, 0, 0);
    @(negedge clk);
    chk("T6 count", fifo_count, 3);
    chk("T6 mask", lsu_pending_mask, 32'h1C00_0000);
    tick();
    rst = 1;
    set_alu(1, 5'd9, 32'h99);
    @(negedge clk);
    chk("T6 rst RegWrite", RegWrite, 0);
    chk("T6 rst count", fifo_count, 0);
    chk("T6 rst mask", lsu_pending_mask, 0);
    tick();
    rst = 0;
    set_alu(0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("T6 no stale write", RegWrite, 0);
      tick();
    end

    // Randomized traffic; sources hold their transfer while stalled
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_hold = alu_valid && !alu_ready && !rst;
      l_hold = lsu_valid && !lsu_ready && !rst;
      tick();
      rst = ($urandom_range(0, 149) == 0);
      if (!a_hold)
        set_alu($urandom_range(0, 9) < 6,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      if (!l_hold)
        set_lsu($urandom_range(0, 9) < 5,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end
    rst = 0;
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    repeat (8) tick();
    @(negedge clk);
    chk("final count", fifo_count, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
